// File: rtl/tutor_pkg.sv
// tutor_pkg
//   Shared definitions for the Smart Math Tutor quiz sequencer:
//   - state_t            : quiz FSM state encoding
//   - LFSR_TAPS          : tap mask of the 8-bit question LFSR (bits 7,5,4,3)
//   - divisor(sel)       : divisor code to divisor value, sel+2 (2..9)
//   - count_width(n)     : width needed to count 0..n
package tutor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASK      = 3'd1,
    ST_WAIT_ANS = 3'd2,
    ST_JUDGE    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Fibonacci feedback is the XOR of the bits selected by this mask.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [3:0] divisor(input logic [2:0] sel);
    return {1'b0, sel} + 4'd2;
  endfunction

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tutor_multiple_checker.sv
// multiple_checker
//   Purely combinational test of whether number is a multiple of the
//   divisor selected by sel (divisor = sel+2, range 2..9).
//   Ports:
//     sel        in  3  divisor code
//     number     in  5  value under test, 0..31
//     ismultiple out 1  1 when number mod divisor == 0 (0 counts as a multiple)
module multiple_checker
  import tutor_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [4:0] number,
  output logic       ismultiple
);

  // One constant-divisor remainder test per code; sel just picks the answer.
  // Constant moduli keep each lane a small fixed function of number.
  logic [7:0] hit;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_div
      assign hit[gi] = ((number % 5'(divisor(3'(gi)))) == 5'd0);
    end
  endgenerate

  assign ismultiple = hit[sel];

endmodule

// File: rtl/tutor_quiz_ctrl.sv
// tutor_quiz_ctrl
//   Quiz sequencer: draws (divisor, number) questions from an 8-bit LFSR,
//   waits for a yes/no answer with a timeout, judges it against
//   multiple_checker and keeps the running score over NUM_QUESTIONS.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start           begin a quiz (IDLE or DONE only)
//     answer_valid    answer strobe (WAIT_ANS only)
//     answer          student claim, 1 = is a multiple
//     sel, number     current question (divisor = sel+2)
//     question_valid  high while waiting for the answer
//     result_valid    one-cycle verdict pulse
//     correct         verdict, held until the next verdict
//     timed_out       verdict came from a timeout, held likewise
//     score, q_count  correct answers / judged questions this quiz
//     done            quiz finished
module tutor_quiz_ctrl
  import tutor_pkg::*;
#(
  parameter int          NUM_QUESTIONS  = 10,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5,
  localparam int         CW             = count_width(NUM_QUESTIONS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          answer_valid,
  input  logic          answer,
  output logic [2:0]    sel,
  output logic [4:0]    number,
  output logic          question_valid,
  output logic          result_valid,
  output logic          correct,
  output logic          timed_out,
  output logic [CW-1:0] score,
  output logic [CW-1:0] q_count,
  output logic          done
);

  localparam int        TW   = $clog2(TIMEOUT_CYCLES);
  localparam [TW-1:0]   TMAX = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [7:0]    lfsr_reg;
  logic [2:0]    sel_reg;
  logic [4:0]    number_reg;
  logic [TW-1:0] timer_reg;
  logic [CW-1:0] score_reg, q_count_reg;
  logic          correct_reg, timed_out_reg;

  logic          ismultiple;
  logic          timeout_hit;
  logic [CW-1:0] q_count_inc;
  logic [7:0]    lfsr_adv;

  multiple_checker u_checker (
    .sel        (sel_reg),
    .number     (number_reg),
    .ismultiple (ismultiple)
  );

  assign timeout_hit = (timer_reg == TMAX);
  assign q_count_inc = q_count_reg + CW'(1);
  assign lfsr_adv    = {lfsr_reg[6:0], ^(lfsr_reg & LFSR_TAPS)};

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE, ST_DONE: if (start) state_next = ST_ASK;
      ST_ASK:           state_next = ST_WAIT_ANS;
      ST_WAIT_ANS:      if (answer_valid || timeout_hit) state_next = ST_JUDGE;
      ST_JUDGE:         state_next = (q_count_inc == CW'(NUM_QUESTIONS)) ? ST_DONE : ST_ASK;
      default:          state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Output decode, straight from the state register
  // ---------------------------------------------------------------
  always_comb begin
    question_valid = 1'b0;
    result_valid   = 1'b0;
    done           = 1'b0;
    unique case (state_reg)
      ST_WAIT_ANS: question_valid = 1'b1;
      ST_JUDGE:    result_valid   = 1'b1;
      ST_DONE:     done           = 1'b1;
      default:     ;
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath: LFSR, question registers, timer, verdict and counters
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg      <= LFSR_SEED;
      sel_reg       <= '0;
      number_reg    <= '0;
      timer_reg     <= '0;
      score_reg     <= '0;
      q_count_reg   <= '0;
      correct_reg   <= 1'b0;
      timed_out_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            score_reg   <= '0;
            q_count_reg <= '0;
          end
        end
        ST_ASK: begin
          sel_reg    <= lfsr_reg[7:5];
          number_reg <= lfsr_reg[4:0];
          lfsr_reg   <= lfsr_adv;
          timer_reg  <= '0;
        end
        ST_WAIT_ANS: begin
          timer_reg <= timer_reg + TW'(1);
          // The verdict is resolved on the exit edge so it is already
          // registered when result_valid is shown. An answer in the final
          // cycle takes priority over the timeout.
          if (answer_valid) begin
            correct_reg   <= (answer == ismultiple);
            timed_out_reg <= 1'b0;
          end else if (timeout_hit) begin
            correct_reg   <= 1'b0;
            timed_out_reg <= 1'b1;
          end
        end
        ST_JUDGE: begin
          q_count_reg <= q_count_inc;
          if (correct_reg) score_reg <= score_reg + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sel       = sel_reg;
  assign number    = number_reg;
  assign correct   = correct_reg;
  assign timed_out = timed_out_reg;
  assign score     = score_reg;
  assign q_count   = q_count_reg;

endmodule

// File: tb/tb_tutor_quiz_ctrl.sv
module tb_tutor_quiz_ctrl;

  localparam int NQ = 3;
  localparam int TO = 4;
  localparam int CW = $clog2(NQ + 1);

  logic          clk = 1'b0;
  logic          rst, start, answer_valid, answer;
  logic [2:0]    sel;
  logic [4:0]    number;
  logic          question_valid, result_valid, correct, timed_out, done;
  logic [CW-1:0] score, q_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state (quiz-level view)
  logic [7:0] m_lfsr;
  int         m_score;
  int         m_q;

  always #5 clk = ~clk;

  tutor_quiz_ctrl #(
    .NUM_QUESTIONS  (NQ),
    .TIMEOUT_CYCLES (TO),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .answer_valid   (answer_valid),
    .answer         (answer),
    .sel            (sel),
    .number         (number),
    .question_valid (question_valid),
    .result_valid   (result_valid),
    .correct        (correct),
    .timed_out      (timed_out),
    .score          (score),
    .q_count        (q_count),
    .done           (done)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; answer_valid = 1'b0; answer = 1'b0;
    step();
    rst = 1'b0;
    m_lfsr = 8'hA5; m_score = 0; m_q = 0;
  endtask

  // Leaves the DUT in its ASK cycle.
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    m_score = 0; m_q = 0;
  endtask

  // Called in WAIT_ANS, 'elapsed' cycles after entry. d = cycle (relative
  // to entry) at which to answer; d >= TO means let it time out.
  // ans_mode 0/1 = that answer, 2 = the right answer.
  task automatic run_question(input string tag, input int elapsed, input int d, input int ans_mode);
    int  e_sel, e_num, n;
    bit  ismul, ans, e_cor, e_to, bad;
    e_sel  = int'(m_lfsr[7:5]);
    e_num  = int'(m_lfsr[4:0]);
    m_lfsr = lfsr_step(m_lfsr);
    ismul  = ((e_num % (e_sel + 2)) == 0);
    ans    = (ans_mode == 2) ? ismul : ans_mode[0];

    checks++;
    if (sel !== 3'(e_sel) || number !== 5'(e_num) || question_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s question got sel=%0d num=%0d qv=%b exp sel=%0d num=%0d qv=1",
               tag, sel, number, question_valid, e_sel, e_num);
    end

    if (d < TO) begin
      bad = 1'b0;
      for (int k = elapsed; k < d; k++) begin
        step();
        if (question_valid !== 1'b1 || result_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s wait_hold qv/rv changed before answer, exp qv=1 rv=0", tag);
      end
      answer_valid = 1'b1; answer = ans;
      step();
      answer_valid = 1'b0; answer = 1'b0;
      e_to = 1'b0; e_cor = (ans == ismul);
    end else begin
      n = elapsed;
      while (question_valid === 1'b1 && n < TO + 8) begin
        n++;
        step();
      end
      checks++;
      if (n != TO) begin
        failures++;
        $display("FAIL %s timeout_len got=%0d exp=%0d", tag, n, TO);
      end
      e_to = 1'b1; e_cor = 1'b0;
    end

    checks++;
    if (result_valid !== 1'b1 || correct !== e_cor || timed_out !== e_to || question_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s verdict got rv=%b cor=%b to=%b qv=%b exp rv=1 cor=%b to=%b qv=0",
               tag, result_valid, correct, timed_out, question_valid, e_cor, e_to);
    end
    m_q++;
    if (e_cor) m_score++;

    step();
    checks++;
    if (result_valid !== 1'b0 || score !== CW'(m_score) || q_count !== CW'(m_q) ||
        done !== (m_q == NQ) || correct !== e_cor || timed_out !== e_to) begin
      failures++;
      $display("FAIL %s after got rv=%b score=%0d q=%0d done=%b cor=%b exp rv=0 score=%0d q=%0d done=%b cor=%b",
               tag, result_valid, score, q_count, done, correct, m_score, m_q, m_q == NQ, e_cor);
    end
    $display("question %s sel=%0d num=%0d ans=%0b d=%0d -> cor=%b to=%b score=%0d q=%0d",
             tag, e_sel, e_num, ans, d, correct, timed_out, score, q_count);
    if (m_q != NQ) step();   // ASK -> now in WAIT_ANS for the next one
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; answer_valid = 1'b1; answer = 1'b1;
    step(); step();
    checks++;
    if (sel !== 3'd0 || number !== 5'd0 || question_valid !== 1'b0 || result_valid !== 1'b0 ||
        correct !== 1'b0 || timed_out !== 1'b0 || score !== '0 || q_count !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got sel=%0d num=%0d qv=%b rv=%b cor=%b to=%b score=%0d q=%0d done=%b exp all 0",
               sel, number, question_valid, result_valid, correct, timed_out, score, q_count, done);
    end
    do_reset();
  endtask

  task automatic test_first_questions();
    do_reset();
    do_start();
    step();
    checks++;
    if (sel !== 3'd5 || number !== 5'd5) begin
      failures++;
      $display("FAIL first_q got sel=%0d num=%0d exp sel=5 num=5", sel, number);
    end
    run_question("q1", 0, 1, 0);
    checks++;
    if (sel !== 3'd2 || number !== 5'd10) begin
      failures++;
      $display("FAIL second_q got sel=%0d num=%0d exp sel=2 num=10", sel, number);
    end
    run_question("q2", 0, 0, 1);
    checks++;
    if (score !== CW'(1)) begin
      failures++;
      $display("FAIL score_after_q2 got=%0d exp=1", score);
    end
    run_question("q3_timeout", 0, TO, 0);
  endtask

  task automatic test_exact_timeout();
    do_start();   // from DONE
    checks++;
    if (score !== '0 || q_count !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear got score=%0d q=%0d done=%b exp 0 0 0", score, q_count, done);
    end
    step();
    run_question("exact_to", 0, TO - 1, int'($urandom_range(0, 1)));
    run_question("exact_to_b", 0, TO - 1, 2);
    run_question("exact_to_c", 0, 0, 2);
  endtask

  task automatic test_ignored_inputs();
    bit bad;
    do_reset();
    bad = 1'b0;
    answer_valid = 1'b1; answer = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (question_valid !== 1'b0 || result_valid !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    answer_valid = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL idle_answer reacted to answer_valid in IDLE, exp qv=0 rv=0 done=0");
    end
    do_start();
    answer_valid = 1'b1; answer = 1'b1;   // in ASK: must be dropped
    step();
    answer_valid = 1'b0;
    checks++;
    if (question_valid !== 1'b1 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL ask_answer got qv=%b rv=%b exp qv=1 rv=0", question_valid, result_valid);
    end
    start = 1'b1;                          // in WAIT_ANS: must be ignored
    step();
    start = 1'b0;
    checks++;
    if (question_valid !== 1'b1 || result_valid !== 1'b0 || q_count !== '0) begin
      failures++;
      $display("FAIL wait_start got qv=%b rv=%b q=%0d exp qv=1 rv=0 q=0", question_valid, result_valid, q_count);
    end
    run_question("ign1", 2, 3, 2);
    run_question("ign2", 0, 2, 0);
    run_question("ign3", 0, 1, 1);
    bad = 1'b0;
    answer_valid = 1'b1; answer = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done !== 1'b1 || result_valid !== 1'b0 || question_valid !== 1'b0 || q_count !== CW'(NQ)) bad = 1'b1;
    end
    answer_valid = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL done_answer reacted to answer_valid in DONE, exp done=1 rv=0 qv=0 q=%0d", NQ);
    end
  endtask

  task automatic test_full_quiz();
    do_reset();
    do_start();
    step();
    for (int i = 0; i < NQ; i++) run_question($sformatf("full%0d", i), 0, int'($urandom_range(0, TO - 1)), 2);
    checks++;
    if (done !== 1'b1 || score !== CW'(3) || q_count !== CW'(3)) begin
      failures++;
      $display("FAIL full_quiz got done=%b score=%0d q=%0d exp done=1 score=3 q=3", done, score, q_count);
    end
    do_start();
    checks++;
    if (score !== '0 || q_count !== '0) begin
      failures++;
      $display("FAIL full_restart got score=%0d q=%0d exp 0 0", score, q_count);
    end
    step();
    checks++;
    if (sel !== 3'd1 || number !== 5'd10) begin
      failures++;
      $display("FAIL after_95 got sel=%0d num=%0d exp sel=1 num=10", sel, number);
    end
    run_question("post95", 0, 0, 2);
  endtask

  task automatic test_rst_mid();
    rst = 1'b1;   // DUT currently in WAIT_ANS
    step();
    rst = 1'b0;
    checks++;
    if (sel !== 3'd0 || number !== 5'd0 || question_valid !== 1'b0 || result_valid !== 1'b0 ||
        correct !== 1'b0 || timed_out !== 1'b0 || score !== '0 || q_count !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got sel=%0d num=%0d qv=%b rv=%b cor=%b to=%b score=%0d q=%0d done=%b exp all 0",
               sel, number, question_valid, result_valid, correct, timed_out, score, q_count, done);
    end
    m_lfsr = 8'hA5; m_score = 0; m_q = 0;
    do_start();
    step();
    checks++;
    if (sel !== 3'd5 || number !== 5'd5) begin
      failures++;
      $display("FAIL rst_replay got sel=%0d num=%0d exp sel=5 num=5", sel, number);
    end
    for (int i = 0; i < NQ; i++) run_question($sformatf("replay%0d", i), 0, 0, 2);
  endtask

  task automatic test_random();
    for (int qz = 0; qz < 12; qz++) begin
      do_start();
      step();
      for (int i = 0; i < NQ; i++)
        run_question($sformatf("rnd%0d_%0d", qz, i), 0,
                     int'($urandom_range(0, TO + 1)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; answer_valid = 1'b0; answer = 1'b0;
    test_reset();
    test_first_questions();
    test_exact_timeout();
    test_ignored_inputs();
    test_full_quiz();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
